// File: rtl/noc_wb_bridge_pkg.sv
// Shared types and header field layout for the NoC-to-Wishbone initiator bridge.
// Request and response headers use the same field positions.
package noc_wb_bridge_pkg;

  localparam int unsigned HDR_WIDTH = 32;
  localparam int unsigned DEST_MSB  = 31;
  localparam int unsigned DEST_LSB  = 27;
  localparam int unsigned CLASS_MSB = 26;
  localparam int unsigned CLASS_LSB = 24;
  localparam int unsigned SRC_MSB   = 23;
  localparam int unsigned SRC_LSB   = 19;
  localparam int unsigned TAG_MSB   = 15;
  localparam int unsigned TAG_LSB   = 8;
  localparam int unsigned WE_BIT    = 1;
  localparam int unsigned ERR_BIT   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP_HDR,
    S_RESP_DAT,
    S_DRAIN
  } state_e;

  // Response header: unlisted bits are zero.
  function automatic logic [HDR_WIDTH-1:0] make_resp_hdr(
    input logic [4:0] dest,
    input logic [2:0] cls,
    input logic [4:0] src,
    input logic [7:0] tag,
    input logic       we,
    input logic       err
  );
    logic [HDR_WIDTH-1:0] h;
    h                     = '0;
    h[DEST_MSB:DEST_LSB]  = dest;
    h[CLASS_MSB:CLASS_LSB] = cls;
    h[SRC_MSB:SRC_LSB]    = src;
    h[TAG_MSB:TAG_LSB]    = tag;
    h[WE_BIT]             = we;
    h[ERR_BIT]            = err;
    return h;
  endfunction

endpackage

// File: rtl/noc_wb_master_bridge_if.sv
// NoC request/response channels plus the Wishbone master bus of the bridge.
// master = bridge side, slave = NoC/Wishbone environment side.
interface noc_wb_master_bridge_if #(
  parameter int unsigned FLIT_WIDTH = 32
);
  logic [FLIT_WIDTH-1:0] noc_in_flit;
  logic                  noc_in_last;
  logic                  noc_in_valid;
  logic                  noc_in_ready;
  logic [FLIT_WIDTH-1:0] noc_out_flit;
  logic                  noc_out_last;
  logic                  noc_out_valid;
  logic                  noc_out_ready;
  logic [31:0]           wbm_adr_o;
  logic [31:0]           wbm_dat_o;
  logic [3:0]            wbm_sel_o;
  logic                  wbm_we_o;
  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic [31:0]           wbm_dat_i;
  logic                  wbm_ack_i;
  logic                  wbm_err_i;

  modport master (
    input  noc_in_flit, noc_in_last, noc_in_valid,
    output noc_in_ready,
    output noc_out_flit, noc_out_last, noc_out_valid,
    input  noc_out_ready,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output noc_in_flit, noc_in_last, noc_in_valid,
    input  noc_in_ready,
    input  noc_out_flit, noc_out_last, noc_out_valid,
    output noc_out_ready,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/noc_wb_bridge_timer.sv
// Saturating 16-bit bus-wait counter; expired_c flags the TIMEOUT-th enabled cycle.
// TIMEOUT = 0 disables expiry.
module noc_wb_bridge_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);
  localparam int unsigned CNT_WIDTH = 16;

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  // count holds the number of enabled cycles already elapsed
  assign expired_c = en && (TIMEOUT != 0) && (count == CNT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/noc_wb_master_bridge.sv
// Runs single-beat NoC request packets as Wishbone classic cycles and returns
// a response packet to the requesting tile. One transaction outstanding.
module noc_wb_master_bridge
  import noc_wb_bridge_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter logic [4:0]  TILEID     = 5'd0,
  parameter logic [2:0]  CLASS      = 3'd2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  noc_wb_master_bridge_if.master bus,
  output logic                   busy
);

  state_e      state, state_next;
  logic [4:0]  src_q;
  logic [7:0]  tag_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        in_fire_c, out_fire_c, in_last_c;
  logic        bus_done_c, bus_err_c, expired_c;

  assign in_fire_c  = bus.noc_in_valid && bus.noc_in_ready;
  assign out_fire_c = bus.noc_out_valid && bus.noc_out_ready;
  assign in_last_c  = bus.noc_in_last;
  // err wins over ack; a timeout only counts if the slave did not ack in that cycle
  assign bus_done_c = bus.wbm_ack_i || bus.wbm_err_i || expired_c;
  assign bus_err_c  = bus.wbm_err_i || (expired_c && !bus.wbm_ack_i);
  assign bus.wbm_sel_o = 4'hf;

  noc_wb_bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state != S_BUS),
    .en        (state == S_BUS),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (in_fire_c && !in_last_c) state_next = S_ADDR;
      S_ADDR: begin
        if (in_fire_c) begin
          case ({in_last_c, we_q})
            2'b10:   state_next = S_BUS;
            2'b01:   state_next = S_DATA;
            2'b00:   state_next = S_DRAIN;
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_DATA:   if (in_fire_c) state_next = in_last_c ? S_BUS : S_DRAIN;
      S_DRAIN:  if (in_fire_c && in_last_c) state_next = S_BUS;
      S_BUS:    if (bus_done_c) state_next = S_RESP_HDR;
      S_RESP_HDR: if (out_fire_c) state_next = we_q ? S_IDLE : S_RESP_DAT;
      S_RESP_DAT: if (out_fire_c) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.noc_in_ready  <= 1'b1;
      bus.noc_out_valid <= 1'b0;
      bus.noc_out_last  <= 1'b0;
      bus.noc_out_flit  <= '0;
      bus.wbm_adr_o     <= '0;
      bus.wbm_dat_o     <= '0;
      bus.wbm_we_o      <= 1'b0;
      bus.wbm_cyc_o     <= 1'b0;
      bus.wbm_stb_o     <= 1'b0;
      busy              <= 1'b0;
      src_q             <= '0;
      tag_q             <= '0;
      we_q              <= 1'b0;
      rdata_q           <= '0;
    end else begin
      bus.noc_in_ready  <= state_next inside {S_IDLE, S_ADDR, S_DATA, S_DRAIN};
      bus.noc_out_valid <= state_next inside {S_RESP_HDR, S_RESP_DAT};
      bus.wbm_cyc_o     <= (state_next == S_BUS);
      bus.wbm_stb_o     <= (state_next == S_BUS);
      busy              <= (state_next != S_IDLE);

      if ((state == S_IDLE) && in_fire_c) begin
        src_q        <= bus.noc_in_flit[SRC_MSB:SRC_LSB];
        tag_q        <= bus.noc_in_flit[TAG_MSB:TAG_LSB];
        we_q         <= bus.noc_in_flit[WE_BIT];
        bus.wbm_we_o <= bus.noc_in_flit[WE_BIT];
      end
      if ((state == S_ADDR) && in_fire_c) bus.wbm_adr_o <= 32'(bus.noc_in_flit);
      if ((state == S_DATA) && in_fire_c) bus.wbm_dat_o <= 32'(bus.noc_in_flit);

      if ((state == S_BUS) && bus_done_c) begin
        rdata_q          <= bus_err_c ? 32'h0 : bus.wbm_dat_i;
        bus.noc_out_flit <= FLIT_WIDTH'(make_resp_hdr(src_q, CLASS, TILEID, tag_q, we_q, bus_err_c));
        bus.noc_out_last <= we_q;
      end
      if ((state == S_RESP_HDR) && out_fire_c && !we_q) begin
        bus.noc_out_flit <= FLIT_WIDTH'(rdata_q);
        bus.noc_out_last <= 1'b1;
      end
      if (out_fire_c && (state_next == S_IDLE)) bus.noc_out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_wb_master_bridge.sv
// Directed self-checking bench for noc_wb_master_bridge (TILEID=7, CLASS=2, TIMEOUT=8).
module tb_noc_wb_master_bridge;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_bus   = 0;
  int   n_out   = 0;
  logic cyc_d   = 1'b0;

  always #5 clk = ~clk;

  noc_wb_master_bridge_if ifc ();

  noc_wb_master_bridge #(
    .FLIT_WIDTH (32),
    .TILEID     (5'd7),
    .CLASS      (3'd2),
    .TIMEOUT    (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc.master),
    .busy (busy)
  );

  // Bus-cycle starts and response flit transfers, for counting only
  always @(posedge clk) begin
    cyc_d <= ifc.wbm_cyc_o;
    if (ifc.wbm_cyc_o && !cyc_d) n_bus++;
    if (ifc.noc_out_valid && ifc.noc_out_ready) n_out++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [31:0] f, input logic last);
    int n = 0;
    ifc.noc_in_flit  = f;
    ifc.noc_in_last  = last;
    ifc.noc_in_valid = 1'b1;
    while (!ifc.noc_in_ready && n < 20) begin tick(); n++; end
    if (!ifc.noc_in_ready) begin
      n_fail++;
      $display("FAIL send_flit: noc_in_ready still %b after %0d cycles, required 1", ifc.noc_in_ready, n);
    end
    tick();
    ifc.noc_in_valid = 1'b0;
    ifc.noc_in_last  = 1'b0;
  endtask

  task automatic slave_resp(input logic ack, input logic err, input logic [31:0] d);
    ifc.wbm_ack_i = ack;
    ifc.wbm_err_i = err;
    ifc.wbm_dat_i = d;
    tick();
    ifc.wbm_ack_i = 1'b0;
    ifc.wbm_err_i = 1'b0;
    ifc.wbm_dat_i = 32'h0;
  endtask

  task automatic recv_flit(output logic [31:0] f, output logic l);
    int n = 0;
    ifc.noc_out_ready = 1'b1;
    while (!ifc.noc_out_valid && n < 20) begin tick(); n++; end
    if (!ifc.noc_out_valid) begin
      n_fail++;
      $display("FAIL recv_flit: noc_out_valid still 0 after %0d cycles, required 1", n);
    end
    f = ifc.noc_out_flit;
    l = ifc.noc_out_last;
    tick();
    ifc.noc_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({ifc.wbm_cyc_o, ifc.wbm_stb_o, ifc.wbm_we_o, ifc.noc_out_valid, ifc.noc_out_last, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: cyc/stb/we/oval/olast/busy=%b required 000000",
               {ifc.wbm_cyc_o, ifc.wbm_stb_o, ifc.wbm_we_o, ifc.noc_out_valid, ifc.noc_out_last, busy});
    end
    n_tests++;
    if ({ifc.wbm_adr_o, ifc.wbm_dat_o, ifc.noc_out_flit} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: adr=%h dat=%h flit=%h required all 0", ifc.wbm_adr_o, ifc.wbm_dat_o, ifc.noc_out_flit);
    end
    n_tests++;
    if (ifc.wbm_sel_o !== 4'hf || ifc.noc_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sel_ready: sel=%h in_ready=%b required f/1", ifc.wbm_sel_o, ifc.noc_in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  // Read with zero-wait ack; also checks the minimum-latency points.
  task automatic test_read();
    int b0 = n_bus;
    int o0 = n_out;
    logic [31:0] f;
    logic l;
    send_flit(32'h0018_5A00, 1'b0);
    send_flit(32'h0000_0100, 1'b0 | 1'b1);
    n_tests++;
    if (ifc.wbm_cyc_o !== 1'b1 || ifc.wbm_stb_o !== 1'b1 || ifc.wbm_adr_o !== 32'h100 || ifc.wbm_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_bus: cyc=%b stb=%b adr=%h we=%b required 1/1/00000100/0",
               ifc.wbm_cyc_o, ifc.wbm_stb_o, ifc.wbm_adr_o, ifc.wbm_we_o);
    end
    n_tests++;
    if (ifc.noc_in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_ready_in_bus: in_ready=%b busy=%b required 0/1", ifc.noc_in_ready, busy);
    end
    slave_resp(1'b1, 1'b0, 32'hDEAD_BEEF);
    n_tests++;
    if (ifc.wbm_cyc_o !== 1'b0 || ifc.noc_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_resp_latency: cyc=%b out_valid=%b required 0/1", ifc.wbm_cyc_o, ifc.noc_out_valid);
    end
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h1A38_5A00 || l !== 1'b0) begin
      n_fail++;
      $display("FAIL read_hdr: flit=%h last=%b required 1a385a00/0", f, l);
    end
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'hDEAD_BEEF || l !== 1'b1) begin
      n_fail++;
      $display("FAIL read_data: flit=%h last=%b required deadbeef/1", f, l);
    end
    n_tests++;
    if (n_bus - b0 !== 1 || n_out - o0 !== 2 || busy !== 1'b0 || ifc.noc_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_counts: bus=%0d out=%0d busy=%b oval=%b required 1/2/0/0",
               n_bus - b0, n_out - o0, busy, ifc.noc_out_valid);
    end
  endtask

  task automatic test_write();
    int o0 = n_out;
    logic [31:0] f;
    logic l;
    send_flit(32'h0048_1102, 1'b0);
    send_flit(32'h0000_0204, 1'b0);
    send_flit(32'h1234_5678, 1'b1);
    n_tests++;
    if (ifc.wbm_cyc_o !== 1'b1 || ifc.wbm_we_o !== 1'b1 || ifc.wbm_adr_o !== 32'h204 ||
        ifc.wbm_dat_o !== 32'h1234_5678 || ifc.wbm_sel_o !== 4'hf) begin
      n_fail++;
      $display("FAIL write_bus: cyc=%b we=%b adr=%h dat=%h sel=%h required 1/1/00000204/12345678/f",
               ifc.wbm_cyc_o, ifc.wbm_we_o, ifc.wbm_adr_o, ifc.wbm_dat_o, ifc.wbm_sel_o);
    end
    slave_resp(1'b1, 1'b0, 32'h0);
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h4A38_1102 || l !== 1'b1) begin
      n_fail++;
      $display("FAIL write_hdr: flit=%h last=%b required 4a381102/1", f, l);
    end
    n_tests++;
    if (n_out - o0 !== 1 || ifc.noc_out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_single_flit: out=%0d oval=%b busy=%b required 1/0/0", n_out - o0, ifc.noc_out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int o0 = n_out;
    logic [31:0] f;
    logic l;
    send_flit(32'h0008_3300, 1'b0);
    send_flit(32'h0000_0040, 1'b1);
    slave_resp(1'b1, 1'b0, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (ifc.noc_out_valid !== 1'b1 || ifc.noc_out_flit !== 32'h0A38_3300 || ifc.noc_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: oval=%b flit=%h in_ready=%b required 1/0a383300/0",
                 i, ifc.noc_out_valid, ifc.noc_out_flit, ifc.noc_in_ready);
      end
      tick();
    end
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h0A38_3300 || l !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hdr: flit=%h last=%b required 0a383300/0", f, l);
    end
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'hCAFE_F00D || l !== 1'b1 || n_out - o0 !== 2) begin
      n_fail++;
      $display("FAIL bp_data: flit=%h last=%b flits=%0d required cafef00d/1/2", f, l, n_out - o0);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    logic [31:0] f;
    logic l;
    send_flit(32'h0010_7700, 1'b0);
    send_flit(32'h0000_0300, 1'b1);
    ifc.wbm_dat_i = 32'hFFFF_FFFF;
    n_tests++;
    if (ifc.wbm_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_start: cyc=%b required 1", ifc.wbm_cyc_o);
    end
    while (ifc.wbm_cyc_o && n < 40) begin tick(); n++; end
    n_tests++;
    if (n !== 8 || ifc.noc_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_len: cyc cycles=%0d oval=%b required 8/1", n, ifc.noc_out_valid);
    end
    ifc.wbm_dat_i = 32'h0;
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h1238_7701 || l !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_hdr: flit=%h last=%b required 12387701/0", f, l);
    end
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h0 || l !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_data: flit=%h last=%b required 00000000/1", f, l);
    end
  endtask

  task automatic test_slave_err();
    logic [31:0] f;
    logic l;
    send_flit(32'h0028_0100, 1'b0);
    send_flit(32'h0000_0600, 1'b1);
    slave_resp(1'b1, 1'b1, 32'h1234_5678);
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h2A38_0101 || l !== 1'b0) begin
      n_fail++;
      $display("FAIL err_hdr: flit=%h last=%b required 2a380101/0", f, l);
    end
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h0 || l !== 1'b1) begin
      n_fail++;
      $display("FAIL err_data: flit=%h last=%b required 00000000/1", f, l);
    end
  endtask

  task automatic test_malformed();
    int b0 = n_bus;
    int o0 = n_out;
    send_flit(32'h0018_5A00, 1'b1);
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || ifc.noc_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL malf_hdr_last: busy=%b in_ready=%b required 0/1", busy, ifc.noc_in_ready);
    end
    send_flit(32'h0048_1102, 1'b0);
    send_flit(32'h0000_0204, 1'b1);
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || n_bus !== b0 || n_out !== o0) begin
      n_fail++;
      $display("FAIL malf_no_activity: busy=%b bus=%0d out=%0d required 0/0/0", busy, n_bus - b0, n_out - o0);
    end
  endtask

  task automatic test_drain();
    int b0 = n_bus;
    int o0 = n_out;
    logic [31:0] f;
    logic l;
    send_flit(32'h0020_1200, 1'b0);
    send_flit(32'h0000_0500, 1'b0);
    n_tests++;
    if (ifc.wbm_cyc_o !== 1'b0 || ifc.noc_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_wait: cyc=%b in_ready=%b required 0/1", ifc.wbm_cyc_o, ifc.noc_in_ready);
    end
    send_flit(32'h0000_AAAA, 1'b0);
    send_flit(32'h0000_BBBB, 1'b1);
    n_tests++;
    if (ifc.wbm_cyc_o !== 1'b1 || ifc.wbm_adr_o !== 32'h500) begin
      n_fail++;
      $display("FAIL drain_bus: cyc=%b adr=%h required 1/00000500", ifc.wbm_cyc_o, ifc.wbm_adr_o);
    end
    slave_resp(1'b1, 1'b0, 32'h0000_0055);
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h2238_1200 || l !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_hdr: flit=%h last=%b required 22381200/0", f, l);
    end
    recv_flit(f, l);
    n_tests++;
    if (f !== 32'h55 || l !== 1'b1 || n_bus - b0 !== 1 || n_out - o0 !== 2) begin
      n_fail++;
      $display("FAIL drain_data: flit=%h last=%b bus=%0d out=%0d required 00000055/1/1/2",
               f, l, n_bus - b0, n_out - o0);
    end
  endtask

  task automatic test_reset_in_bus();
    int o0;
    send_flit(32'h0018_5A00, 1'b0);
    send_flit(32'h0000_0100, 1'b1);
    o0 = n_out;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (ifc.wbm_cyc_o !== 1'b0 || ifc.wbm_stb_o !== 1'b0 || busy !== 1'b0 || ifc.noc_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_bus: cyc=%b stb=%b busy=%b in_ready=%b required 0/0/0/1",
               ifc.wbm_cyc_o, ifc.wbm_stb_o, busy, ifc.noc_in_ready);
    end
    ifc.noc_out_ready = 1'b1;
    repeat (4) tick();
    ifc.noc_out_ready = 1'b0;
    n_tests++;
    if (n_out !== o0 || ifc.noc_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_resp: flits=%0d oval=%b required 0/0", n_out - o0, ifc.noc_out_valid);
    end
  endtask

  initial begin
    rst               = 1'b1;
    ifc.noc_in_flit   = '0;
    ifc.noc_in_last   = 1'b0;
    ifc.noc_in_valid  = 1'b0;
    ifc.noc_out_ready = 1'b0;
    ifc.wbm_dat_i     = '0;
    ifc.wbm_ack_i     = 1'b0;
    ifc.wbm_err_i     = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_timeout();
    test_slave_err();
    test_malformed();
    test_drain();
    test_reset_in_bus();
    test_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
